// File: rtl/rf_write_scheduler.sv
// Round-robin write-port scheduler for the 8x4 register file, with WRITE, ADD and CLEAR.
// Define RF_ADD_SAT_EN to make ADD saturate instead of wrap.
module rf_write_scheduler #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              clear_start,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [AW-1:0]     RF_add1,
  input  logic [DW-1:0]     RF_d1,
  output logic              RF_we,
  output logic [AW-1:0]     RF_wa,
  output logic [DW-1:0]     RF_wd
);

  localparam logic [2:0] LastRst = 3'(NREQ - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [2:0]      last_q, grant_id_q;
  logic            stg_vld_q, stg_op_q;
  logic [AW-1:0]   stg_addr_q, add1_q;
  logic [DW-1:0]   stg_data_q;

  logic            accept;
  logic [2:0]      win;
  logic            sel_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [DW-1:0]   add_res;

  // Search starts one past the last winner; the first valid requester in that order wins.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    win       = last_q;
    sel_op    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (state_q == StIdle && !clear_start) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        for (int unsigned j = 0; j < NREQ; j++) begin
          if (!accept && req_valid[j] && (j == (32'(last_q) + k) % NREQ)) begin
            accept       = 1'b1;
            win          = 3'(j);
            req_ready[j] = 1'b1;
            sel_op       = req_op[j];
            sel_addr     = req_addr[j*AW +: AW];
            sel_data     = req_data[j*DW +: DW];
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = StIdle;
      end
    endcase
  end

`ifdef RF_ADD_SAT_EN
  logic [DW:0] sum_ext;
  assign sum_ext = {1'b0, RF_d1} + {1'b0, stg_data_q};
  assign add_res = sum_ext[DW] ? '1 : sum_ext[DW-1:0];
`else
  assign add_res = RF_d1 + stg_data_q;
`endif

  always_comb begin
    RF_we = 1'b0;
    RF_wa = '0;
    RF_wd = '0;
    if (state_q == StClear) begin
      RF_we = 1'b1;
      RF_wa = clr_cnt_q;
    end else if (stg_vld_q) begin
      RF_we = 1'b1;
      RF_wa = stg_addr_q;
      RF_wd = stg_op_q ? add_res : stg_data_q;
    end
  end

  // Read address tracks the staged ADD and otherwise holds its last value.
  assign RF_add1  = (stg_vld_q && stg_op_q) ? stg_addr_q : add1_q;
  assign busy     = (state_q == StClear) || stg_vld_q;
  assign grant_id = grant_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      last_q     <= LastRst;
      grant_id_q <= LastRst;
      stg_vld_q  <= 1'b0;
      stg_op_q   <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      add1_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      stg_vld_q <= accept;
      if (accept) begin
        last_q     <= win;
        grant_id_q <= win;
        stg_op_q   <= sel_op;
        stg_addr_q <= sel_addr;
        stg_data_q <= sel_data;
      end
      if (stg_vld_q && stg_op_q) add1_q <= stg_addr_q;
    end
  end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the single write port of the 8x4-bit register file between NREQ requesters using round-robin arbitration.
- Supports two request operations:
  - WRITE: stores the data.
  - ADD: read-modify-write `reg <= reg + data`, using read port 1.
- Provides a CLEAR sequence that zeroes all 8 registers. The register file has no reset of its own, so this is the only way to clear it at runtime.
- Sits between the control/datapath requesters and the register file's write port and port-1 read address.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 3, register address width (register file depth = 2**AW = 8).
- DW, 4, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  NREQ  per-requester op: 0 = WRITE, 1 = ADD.
- req_addr  in  NREQ*AW  packed target addresses; requester i occupies [i*AW +: AW].
- req_data  in  NREQ*DW  packed operands; requester i occupies [i*DW +: DW].
- clear_start  in  1  pulse that starts the CLEAR sequence.
- busy  out  1  high while CLEAR runs or a write is pending.
- grant_id  out  3  index of the last accepted requester.
- RF_add1  out  AW  register file read address 1 (used for ADD).
- RF_d1  in  DW  register file read data 1.
- RF_we  out  1  register file write enable.
- RF_wa  out  AW  register file write address.
- RF_wd  out  DW  register file write data.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, busy=0, grant_id=NREQ-1, RF_we=0, RF_wa=0, RF_wd=0, RF_add1=0.
  - Internal: FSM=IDLE, stage register empty, round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
- FSM states:
  - IDLE: arbitrate requests.
  - CLEAR: address counter clr_cnt runs 0..7.
- Transitions:
  - IDLE -> CLEAR when clear_start=1.
  - CLEAR -> IDLE after the cycle that writes address 7.
  - clear_start is ignored while in CLEAR.
- Arbitration (IDLE only, combinational):
  - Search order starts at last+1 and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one ready bit is high.
  - On accept: last <= i and grant_id <= i.
  - While clear_start=1 or FSM=CLEAR, req_ready=0; clear has priority over any request in the same cycle.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - A requester holds valid, op, addr and data stable until accepted.
  - req_valid must not depend on req_ready.
- Pipeline, 1-cycle latency:
  - An accepted request is latched into the stage register at edge N.
  - During cycle N+1 the block drives RF_we=1 and RF_wa=addr.
  - RF_wd = data for WRITE, or RF_d1+data for ADD, with RF_add1=addr.
  - The write commits at edge N+2's start, i.e. the rising edge ending cycle N+1.
  - The stage is empty after issue; RF_we=0 when it is empty.
  - Back-to-back requests are accepted every cycle, sustaining one write per cycle.
- Read-after-write:
  - An ADD accepted one cycle after a write to the same address reads the updated value.
  - The read happens a cycle after the prior write commits, so no forwarding is needed.
- Arithmetic: ADD is DW bits wide and wraps modulo 2**DW (15+1 -> 0) unless the optional feature is enabled.
- CLEAR sequence:
  - clear_start at edge N: no request is accepted in cycle N. Any stage write from cycle N-1 issues in cycle N as normal.
  - Cycles N+1..N+8: RF_we=1, RF_wa=clr_cnt, RF_wd=0.
  - IDLE resumes at N+9.
- busy = (FSM==CLEAR) | stage occupied.
- RF_add1 = stage addr when the stage holds an ADD; otherwise it holds its previous value.
- Reset mid-operation:
  - Reset aborts CLEAR and drops any staged write.
  - Registers not yet cleared keep their contents.
- Simultaneous events:
  - All NREQ requesters valid -> granted in rotation, one per cycle.
  - clear_start together with requests -> CLEAR wins; requests wait.

Optional Feature:
- Macro: RF_ADD_SAT_EN.
- Defined: ADD saturates at 2**DW-1 (12+7 -> 15).
- Undefined: ADD wraps (12+7 -> 3).
- WRITE and CLEAR are unaffected in both cases.

Test Plan:
- Reset, then requester 0 WRITE addr 3 data 9 -> req_ready[0]=1 in the same cycle; next cycle RF_we=1, RF_wa=3, RF_wd=9; busy=1 for 1 cycle.
- All 3 requesters valid continuously, each writing its index to addr 5 -> grants 0,1,2,0,1,2 on consecutive cycles; RF_wd sequence 0,1,2,0.
- WRITE addr 2 data 6, then ADD addr 2 data 5 on the next cycle -> second write RF_wd=11, RF_add1=2; with RF_ADD_SAT_EN, ADD 7 to 11 -> 15, otherwise -> 2.
- clear_start while requester 1 is valid -> req_ready=0 for 9 cycles; RF_wa=0..7 with RF_wd=0; requester 1 is granted at cycle 9; busy=1 throughout.
- Reset asserted after 3 CLEAR writes -> RF_we=0 the next cycle; registers 3..7 keep their old values; FSM back in IDLE.
- clear_start during CLEAR -> ignored; exactly 8 writes occur.
